// File: rtl/temp_scan_if.sv
// Bundle between temp_scan_controller, the sensor input bank, the shared
// abnormality detector and the plant alarm/status logic.
interface temp_scan_if #(
  parameter int NUM_CH = 4
);
  localparam int CHW = $clog2(NUM_CH);

  logic                  scanEn;
  logic                  clearAlarm;
  logic [7:0]            factoryBaseTemp;
  logic [NUM_CH*4-1:0]   coefVec;
  logic [NUM_CH*4-1:0]   sensorVec;
  logic [7:0]            detBaseTemp;
  logic [3:0]            detTempCoef;
  logic [3:0]            detSensorValue;
  logic                  detAbnormality;
  logic [CHW-1:0]        curCh;
  logic                  busy;
  logic                  scanDone;
  logic [NUM_CH-1:0]     alarmVec;

  modport slave (
    input  scanEn, clearAlarm, factoryBaseTemp, coefVec, sensorVec, detAbnormality,
    output detBaseTemp, detTempCoef, detSensorValue, curCh, busy, scanDone, alarmVec
  );

  modport master (
    output scanEn, clearAlarm, factoryBaseTemp, coefVec, sensorVec, detAbnormality,
    input  detBaseTemp, detTempCoef, detSensorValue, curCh, busy, scanDone, alarmVec
  );
endinterface

// File: rtl/temp_scan_controller.sv
// Time-shares one abnormality detector across NUM_CH channels and tracks
// consecutive abnormal samples per channel. Optional: ALARM_LATCH_EN (sticky alarms).
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | not scanning; det* outputs hold
//   DRIVE  | det* registers load channel ch at the end of this cycle
//   SAMPLE | detector settled; counter of channel ch updates at cycle end
//   WAIT   | INTERVAL idle cycles between scans; det* outputs hold
module temp_scan_controller #(
  parameter int NUM_CH   = 4,
  parameter int THRESH   = 3,
  parameter int INTERVAL = 8
) (
  input  logic       clk,
  input  logic       rst,
  temp_scan_if.slave bus
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(THRESH + 1);
  localparam int WW  = $clog2(INTERVAL + 2);
  localparam logic [WW-1:0] WAIT_LOAD = WW'((INTERVAL > 0) ? INTERVAL - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [CHW-1:0]  ch, ch_nxt;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            done_nxt, scan_done;
  logic            last_ch;
  logic [7:0]      det_base;
  logic [3:0]      det_coef, det_sens;
  logic [CW-1:0]   cnt     [NUM_CH];
  logic [CW-1:0]   cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] hit, alarm, alarm_nxt;

  assign last_ch = (ch == CHW'(NUM_CH - 1));

  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    wait_cnt_nxt = wait_cnt;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.scanEn) begin
          state_nxt = DRIVE;
          ch_nxt    = '0;
        end
      end
      DRIVE: state_nxt = SAMPLE;
      SAMPLE: begin
        if (!last_ch) begin
          ch_nxt    = ch + 1'b1;
          state_nxt = DRIVE;
        end else begin
          done_nxt = 1'b1;
          ch_nxt   = '0;
          if (INTERVAL > 0) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = bus.scanEn ? DRIVE : IDLE;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == '0) state_nxt = bus.scanEn ? DRIVE : IDLE;
        else                wait_cnt_nxt = wait_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the channel being sampled moves; abnormal saturates at THRESH.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) cnt_nxt[i] = cnt[i];
    if (state == SAMPLE) begin
      if (!bus.detAbnormality)          cnt_nxt[ch] = '0;
      else if (cnt[ch] != CW'(THRESH))  cnt_nxt[ch] = cnt[ch] + 1'b1;
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) hit[i] = (cnt_nxt[i] == CW'(THRESH));
  end

`ifdef ALARM_LATCH_EN
  // A set landing in the same cycle as clearAlarm wins.
  assign alarm_nxt = hit | (alarm & ~{NUM_CH{bus.clearAlarm}});
`else
  logic unused_clear;
  assign unused_clear = bus.clearAlarm;
  assign alarm_nxt    = hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      wait_cnt  <= '0;
      scan_done <= 1'b0;
      alarm     <= '0;
      det_base  <= '0;
      det_coef  <= '0;
      det_sens  <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      wait_cnt  <= wait_cnt_nxt;
      scan_done <= done_nxt;
      alarm     <= alarm_nxt;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
      if (state == DRIVE) begin
        det_base <= bus.factoryBaseTemp;
        det_coef <= bus.coefVec[4*ch +: 4];
        det_sens <= bus.sensorVec[4*ch +: 4];
      end
    end
  end

  assign bus.detBaseTemp    = det_base;
  assign bus.detTempCoef    = det_coef;
  assign bus.detSensorValue = det_sens;
  assign bus.curCh          = ch;
  assign bus.busy           = (state == DRIVE) || (state == SAMPLE);
  assign bus.scanDone       = scan_done;
  assign bus.alarmVec       = alarm;
endmodule

// File: tb/tb_temp_scan_controller.sv
// Self-checking bench for temp_scan_controller with default parameters; the
// detector is modelled as abnormal iff detSensorValue == 4'hF.
module tb_temp_scan_controller;
`ifdef ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk;
  logic rst;

  temp_scan_if #(.NUM_CH(4)) bus ();

  temp_scan_controller #(.NUM_CH(4), .THRESH(3), .INTERVAL(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.detAbnormality = (bus.detSensorValue == 4'hF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scan period, offset 1 = DRIVE of channel 0.
  typedef struct {
    int         off;
    logic       busy;
    logic [1:0] ch;
    logic       done;
    int         ndone;
    logic       det_chk;
    logic [1:0] det_ch;
  } vec_t;

  typedef struct packed {
    logic [3:0] prev;
    logic [3:0] next;
  } sb_t;

  vec_t        tbl [16];
  sb_t         sbq [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] coef_v = 16'h3C5A;
  logic [15:0] sens_v = 16'h0000;
  logic [7:0]  base_v = 8'h5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic run_scan(input logic [15:0] sens, input logic [3:0] prev,
                          input logic [3:0] next, input int clr_at, input int en_off_at);
    sb_t        cur;
    logic [3:0] mask;
    logic [3:0] exp_al;
    int         dch;
    sens_v        = sens;
    bus.sensorVec = sens;
    cur.prev = prev;
    cur.next = next;
    sbq.push_back(cur);
    for (int k = 0; k < 16; k++) begin
      if (clr_at > 0 && k + 1 == clr_at) bus.clearAlarm = 1'b1;
      @(posedge clk); #1;
      bus.clearAlarm = 1'b0;
      if (tbl[k].done) begin
        if (sbq.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else cur = sbq.pop_front();
      end
      mask   = 4'((1 << tbl[k].ndone) - 1);
      exp_al = (clr_at > 0 && k + 1 >= clr_at) ? cur.next
                                               : ((cur.next & mask) | (cur.prev & ~mask));
      chk($sformatf("busy@%0d", tbl[k].off), bus.busy, tbl[k].busy);
      chk($sformatf("curCh@%0d", tbl[k].off), bus.curCh, tbl[k].ch);
      chk($sformatf("scanDone@%0d", tbl[k].off), bus.scanDone, tbl[k].done);
      chk($sformatf("alarmVec@%0d", tbl[k].off), bus.alarmVec, exp_al);
      if (tbl[k].det_chk) begin
        dch = tbl[k].det_ch;
        chk($sformatf("detTempCoef@%0d", tbl[k].off), bus.detTempCoef, 4'(coef_v >> (4*dch)));
        chk($sformatf("detSensorValue@%0d", tbl[k].off), bus.detSensorValue, 4'(sens_v >> (4*dch)));
        chk($sformatf("detBaseTemp@%0d", tbl[k].off), bus.detBaseTemp, base_v);
      end
      if (en_off_at == k + 1) bus.scanEn = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      int o;
      o = k + 1;
      tbl[k].off     = o;
      tbl[k].busy    = (o <= 8);
      tbl[k].ch      = (o <= 8) ? 2'((o - 1) / 2) : 2'd0;
      tbl[k].done    = (o == 9);
      tbl[k].ndone   = (o <= 8) ? (o - 1) / 2 : 4;
      tbl[k].det_chk = (o != 1);
      tbl[k].det_ch  = (o > 8) ? 2'd3 : ((o % 2 == 0) ? 2'((o - 1) / 2) : 2'((o - 1) / 2 - 1));
    end

    rst                 = 1'b1;
    bus.scanEn          = 1'b1;
    bus.clearAlarm      = 1'b0;
    bus.factoryBaseTemp = base_v;
    bus.coefVec         = coef_v;
    bus.sensorVec       = sens_v;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_scanDone", bus.scanDone, 0);
    chk("rst_alarmVec", bus.alarmVec, 0);
    chk("rst_curCh", bus.curCh, 0);
    chk("rst_detBaseTemp", bus.detBaseTemp, 0);
    chk("rst_detTempCoef", bus.detTempCoef, 0);
    chk("rst_detSensorValue", bus.detSensorValue, 0);
    rst = 1'b0;

    // threshold on channel 2
    run_scan(16'h0F00, 4'b0000, 4'b0000, 0, 0);
    run_scan(16'h0F00, 4'b0000, 4'b0000, 0, 0);
    run_scan(16'h0F00, 4'b0000, 4'b0100, 0, 0);
    // channel 1 abnormal 2, normal 1, abnormal 2: never alarms
    run_scan(16'h00F0, 4'b0100, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h00F0, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h0000, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h00F0, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h00F0, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    // channel 0 alarm, then back to normal, then clearAlarm
    run_scan(16'h000F, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h000F, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0100 : 4'b0000, 0, 0);
    run_scan(16'h000F, LATCH ? 4'b0100 : 4'b0000, LATCH ? 4'b0101 : 4'b0001, 0, 0);
    run_scan(16'h0000, LATCH ? 4'b0101 : 4'b0001, LATCH ? 4'b0101 : 4'b0000, 0, 0);
    run_scan(16'h0000, LATCH ? 4'b0101 : 4'b0000, 4'b0000, 3, 0);
    // re-arm channel 0 alarm for the reset case
    run_scan(16'h000F, 4'b0000, 4'b0000, 0, 0);
    run_scan(16'h000F, 4'b0000, 4'b0000, 0, 0);
    run_scan(16'h000F, 4'b0000, 4'b0001, 0, 0);

    // rst during SAMPLE of channel 0 with an alarm set
    @(posedge clk); #1;
    chk("pre_rst_drive_busy", bus.busy, 1);
    @(posedge clk); #1;
    chk("pre_rst_sample_busy", bus.busy, 1);
    chk("pre_rst_alarmVec", bus.alarmVec, 4'b0001);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_alarmVec", bus.alarmVec, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_curCh", bus.curCh, 0);
    chk("mid_rst_scanDone", bus.scanDone, 0);
    chk("mid_rst_detTempCoef", bus.detTempCoef, 0);
    chk("mid_rst_detSensorValue", bus.detSensorValue, 0);
    rst        = 1'b0;
    bus.scanEn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 0);
    end

    // scanEn drops during SAMPLE of channel 1: scan completes, then IDLE
    bus.scanEn = 1'b1;
    run_scan(16'h0000, 4'b0000, 4'b0000, 0, 4);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("after_stop_busy", bus.busy, 0);
      chk("after_stop_scanDone", bus.scanDone, 0);
      chk("after_stop_curCh", bus.curCh, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
